// File: rtl/resp_frame_decoder.sv
// Response frame decoder: mid-bit sampling of the sliced read-window stream, 23-bit frame checks, timeout.
// Optional 2-of-3 majority sampling and confirmed start edge when DECODER_GLITCH_FILTER_EN is defined.
module resp_frame_decoder #(
    parameter int BIT_CYCLES     = 200000,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       read_en,
    input  logic       din,
    output logic       busy,
    output logic       frame_valid,
    output logic [1:0] frame_mode,
    output logic [1:0] frame_type,
    output logic [7:0] frame_data,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       timeout,
    output logic [7:0] sum_chk
);

    typedef enum logic [2:0] {IDLE, HUNT, ALIGN, SHIFT, CHECK, DONE} state_t;

    localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LD  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0]       PREAMBLE = 6'b101010;
    localparam logic [3:0]       TRAILER  = 4'b0101;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  bit_cnt, tmo_cnt, bit_ld_val;
    logic [4:0]        nbits;
    logic [16:0]       shreg, shreg_nx;
    logic              read_en_q, din_d1;
    logic              samp_bit, rise, bit_zero, tmo_hit;
    logic              tmo_clr, tmo_inc, tmo_pulse, bit_ld, bit_dec, shift_en;
    logic              pre_err, chk_ok, chk_err;
    logic [1:0]        chk_code;

`ifdef DECODER_GLITCH_FILTER_EN
    logic din_d2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Sampling one cycle late lets the majority window straddle the nominal mid-bit point.
    assign samp_bit = maj3(din_d2, din_d1, din);
    assign rise     = din & din_d1 & ~din_d2;
`else
    assign samp_bit = din;
    assign rise     = din & ~din_d1;
`endif

    // Only the last 17 bits (mode..trailer) are kept; the preamble is checked on the fly.
    assign shreg_nx = {shreg[15:0], samp_bit};
    assign bit_zero = (bit_cnt == '0);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign busy     = (state == ALIGN) || (state == SHIFT);

    always_comb begin
        state_nx   = state;
        tmo_clr    = 1'b0;
        tmo_inc    = 1'b0;
        tmo_pulse  = 1'b0;
        bit_ld     = 1'b0;
        bit_ld_val = FULL_LD;
        bit_dec    = 1'b0;
        shift_en   = 1'b0;
        pre_err    = 1'b0;
        chk_ok     = 1'b0;
        chk_err    = 1'b0;
        chk_code   = 2'b00;
        case (state)
            IDLE: begin
                if (read_en && !read_en_q) begin
                    tmo_clr  = 1'b1;
                    state_nx = HUNT;
                end
            end
            HUNT: begin
                if (rise) begin
                    bit_ld     = 1'b1;
                    bit_ld_val = HALF_LD;
                    state_nx   = ALIGN;
                end
            end
            ALIGN, SHIFT: begin
                if (bit_zero) begin
                    shift_en = 1'b1;
                    bit_ld   = 1'b1;
                    state_nx = SHIFT;
                    if (state == SHIFT && nbits == 5'd5 && shreg_nx[5:0] != PREAMBLE) begin
                        pre_err  = 1'b1;
                        chk_code = 2'b01;
                        state_nx = HUNT;
                    end else if (state == SHIFT && nbits == 5'd22) begin
                        state_nx = CHECK;
                    end
                end else begin
                    bit_dec = 1'b1;
                end
            end
            CHECK: begin
                if (shreg[3:0] != TRAILER) begin
                    chk_err  = 1'b1;
                    chk_code = 2'b11;
                    state_nx = HUNT;
                end else if (shreg[4] != ^shreg[12:5]) begin
                    chk_err  = 1'b1;
                    chk_code = 2'b10;
                    state_nx = HUNT;
                end else begin
                    chk_ok   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase

        // A CHECK verdict on the expiry cycle takes precedence over the timeout pulse.
        if (read_en && state != IDLE && state != DONE) begin
            tmo_inc = 1'b1;
            if (tmo_hit) begin
                state_nx  = DONE;
                tmo_pulse = (state != CHECK);
            end
        end

        // Window closed early: drop everything silently.
        if (!read_en && state != IDLE) begin
            state_nx  = IDLE;
            pre_err   = 1'b0;
            chk_ok    = 1'b0;
            chk_err   = 1'b0;
            tmo_pulse = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            read_en_q   <= 1'b0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            nbits       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            timeout     <= 1'b0;
            frame_mode  <= '0;
            frame_type  <= '0;
            frame_data  <= '0;
            err_code    <= '0;
            sum_chk     <= '0;
        end else begin
            state       <= state_nx;
            read_en_q   <= read_en;
            frame_valid <= chk_ok;
            frame_err   <= pre_err | chk_err;
            timeout     <= tmo_pulse;
            if (pre_err || chk_err) err_code <= chk_code;
            if (chk_ok) begin
                frame_mode <= shreg[16:15];
                frame_type <= shreg[14:13];
                frame_data <= shreg[12:5];
                sum_chk    <= sum_chk + shreg[12:5];
            end
            if (tmo_clr)      tmo_cnt <= '0;
            else if (tmo_inc) tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (bit_ld)       bit_cnt <= bit_ld_val;
            else if (bit_dec) bit_cnt <= bit_cnt - CNT_W'(1);
            if (state == HUNT)  nbits <= '0;
            else if (shift_en)  nbits <= nbits + 5'd1;
        end
    end

    // Line history and shift register carry data only, no reset needed.
    always_ff @(posedge clk) begin
        din_d1 <= din;
`ifdef DECODER_GLITCH_FILTER_EN
        din_d2 <= din_d1;
`endif
        if (shift_en) shreg <= shreg_nx;
    end

endmodule

// File: doc/resp_frame_decoder.md
Name: resp_frame_decoder

Overview:
- Downstream consumer of the comparator-level bit stream `din` produced by the ADC slicer during the read window of the SWIPT data link.
- Recovers one 23-bit response frame per read window using mid-bit sampling, and checks the preamble, even parity and trailer.
- Presents the decoded mode, type and data byte to the link controller with a one-cycle valid or error pulse.
- Also reports a timeout when no frame arrives in the read window.

Parameters:
- BIT_CYCLES, 200000: clock cycles per bit. Minimum 4; must be even.
- TIMEOUT_CYCLES, 2500000: cycles from `read_en` rising with no completed frame before `timeout` fires.
- CNT_W, 24: width of the bit and timeout counters. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- read_en  in  1  read window open; level, from the link controller
- din  in  1  sliced response bit stream, already synchronous to `clk`
- busy  out  1  high in ALIGN or SHIFT
- frame_valid  out  1  one-cycle pulse: good frame decoded
- frame_mode  out  2  decoded mode; held until the next good frame
- frame_type  out  2  decoded type; held until the next good frame
- frame_data  out  8  decoded data byte; held until the next good frame
- frame_err  out  1  one-cycle pulse: frame rejected
- err_code  out  2  01 preamble, 10 parity, 11 trailer; held until the next `frame_err`
- timeout  out  1  one-cycle pulse: read window expired with no good frame
- sum_chk  out  8  modulo-256 sum of `frame_data` over all good frames since reset

Behaviour:
- Frame format, 23 bits, MSB first: preamble 101010, mode[1:0], type[1:0], data[7:0], parity (= ^data, even), trailer 0101.
- Reset: every output 0, state IDLE, all counters 0. Reset wins over every other event, including mid-frame.
- IDLE:
  - `read_en` = 0 holds IDLE.
  - On `read_en` 0->1: clear the timeout counter, go to HUNT.
- HUNT:
  - Track the previous `din`.
  - A `din` 0->1 edge (first preamble bit) goes to ALIGN and loads the bit counter with BIT_CYCLES/2 - 1.
- ALIGN:
  - Count down. At 0, sample `din` into the shift register (bit index 22), go to SHIFT, and reload the counter with BIT_CYCLES - 1.
- SHIFT:
  - Count down. At 0, sample the next bit and reload.
  - After the 6th sample, if the preamble != 101010: pulse `frame_err`, set `err_code`=01, return to HUNT.
  - After the 23rd sample, go to CHECK.
- CHECK (single cycle). Checks are applied in priority order; the outputs update on the cycle after CHECK, i.e. 2 cycles after the 23rd sample edge.
  - Trailer != 0101: error, `err_code`=11.
  - Else parity mismatch: error, `err_code`=10.
  - Else good: pulse `frame_valid`, load `frame_mode`/`frame_type`/`frame_data`, and `sum_chk` += data (wraps at 256).
  - After a good frame, go to DONE. After an error, go to HUNT.
- DONE: wait for `read_en` = 0, then go to IDLE. No further frames or timeouts are reported in this window.
- Timeout:
  - The counter increments each cycle while `read_en` = 1 and state is not DONE.
  - Reaching TIMEOUT_CYCLES pulses `timeout` once and forces DONE, even mid-frame.
  - If timeout and CHECK fall on the same cycle, the CHECK result is reported and `timeout` is suppressed.
- `read_en` falling in any state other than IDLE:
  - Abort to IDLE immediately.
  - No pulse; the partial frame is discarded; held outputs are unchanged.
- All pulses are exactly one cycle wide. `frame_valid` and `frame_err` are mutually exclusive.

Optional Feature:
- Macro: `DECODER_GLITCH_FILTER_EN`.
- Defined:
  - Each bit value is the 2-of-3 majority of `din` at the sample point -1, 0 and +1 cycles.
  - The HUNT edge must be confirmed by `din`=1 on 2 consecutive cycles.
  - The sample point is delayed by 1 cycle, so the CHECK outputs are 1 cycle later.
- Undefined:
  - Single sample at the counter zero.
  - The HUNT edge is a single-cycle 0->1 transition.

Test Plan:
All scenarios use BIT_CYCLES=8, TIMEOUT_CYCLES=400.
- Good frame: mode=01, type=11, data=0xA5, parity=0 -> one `frame_valid` 2 cycles after the 23rd sample; `frame_mode`=01, `frame_type`=11, `frame_data`=A5, `sum_chk`=A5. A second window with data 0x6B gives `sum_chk`=0x10 (wrap).
- Parity flipped on data=0x01 -> `frame_err`, `err_code`=10, no `frame_valid`, `sum_chk` unchanged. A good frame following in the same window is then accepted.
- Preamble 101110 -> `frame_err` with `err_code`=01 right after the 6th sample; the decoder returns to HUNT. Trailer 0111 on an otherwise good frame -> `err_code`=11.
- `read_en` held 1 with `din`=0 -> `timeout` pulse at cycle 400 after the rise, then silence until `read_en` toggles. Dropping `read_en` at bit 10 of a frame -> no pulses, `busy`=0 next cycle.
- Assert `rst` mid-SHIFT, and separately on the same cycle as CHECK -> all outputs 0 next cycle; no `frame_valid` is emitted.
- With `DECODER_GLITCH_FILTER_EN`: inject 1-cycle `din` glitches at the sample points of a good frame -> still decoded correctly. Without the macro, the same stimulus -> `frame_err`.
